scan_mux_reg: RTL and testbench

- Parametrised N-channel, W-bit word multiplexer. Successor to the fixed 1-bit 4:1 mux-tree block.
- Adds a registered output stage with valid/ready handshake, an auto-scan mode with a programmable per-channel dwell, a frame marker and an out-of-range select flag.
- Sits between a bank of parallel sources (switch/counter/ALU results) and a single serial consumer such as a display driver or shift-out stage.

---
 rtl/mux_pkg.sv | 16 +
 rtl/scan_mux_reg_if.sv | 31 +++
 rtl/mux_word_n.sv | 24 ++
 rtl/scan_mux_reg.sv | 109 ++++++++++
 tb/tb_scan_mux_reg.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the scan mux family: mode encodings and the index-width helper.
// Imported by the interface, the word selector and the registered top.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to index n items, never less than one so a single-entry counter still has a bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/scan_mux_reg_if.sv
// Bus between the parallel sources/consumer and scan_mux_reg: select controls, packed inputs,
// and the registered sample with its valid/ready handshake.
interface scan_mux_reg_if #(
  parameter int W = 1,
  parameter int N = 4
) ();

  localparam int SW = mux_pkg::idx_width(N);

  logic           en;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] din;
  logic [W-1:0]   dout;
  logic [SW-1:0]  dout_ch;
  logic           dout_valid;
  logic           dout_ready;
  logic           dout_last;
  logic           dout_err;

  modport master (
    output en, mode, sel, din, dout_ready,
    input  dout, dout_ch, dout_valid, dout_last, dout_err
  );

  modport slave (
    input  en, mode, sel, din, dout_ready,
    output dout, dout_ch, dout_valid, dout_last, dout_err
  );

endinterface

// File: rtl/mux_word_n.sv
// Combinational N:1 W-bit word select; an index at or beyond N yields zero and raises err_o.
// Zero latency, no handshake.
module mux_word_n #(
  parameter int W  = 1,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N*W-1:0] din_i,
  input  logic [SW-1:0]  idx_i,
  output logic [W-1:0]   word_o,
  output logic           err_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_i == SW'(k)) word_o = din_i[k*W +: W];
    end
  end

  // Extra bit keeps N itself representable when N is a power of two.
  assign err_o = ({1'b0, idx_i} >= (SW + 1)'(N));

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel word mux with manual select or auto-scan (DWELL samples per channel).
// One-cycle latency from take to dout; a stalled sample holds and freezes the scan position.
module scan_mux_reg
  import mux_pkg::*;
#(
  parameter int W     = 1,
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic         clk,
  input  logic         reset,
  scan_mux_reg_if.slave bus
);

  localparam int SW  = idx_width(N);
  localparam int DCW = idx_width(DWELL);

  logic [W-1:0]   dout_q, dout_d;
  logic [SW-1:0]  ch_q, ch_d;
  logic           vld_q, vld_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic [SW-1:0]  scan_idx_q, scan_idx_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  logic           scan_mode;
  logic           take;
  logic           dwell_done;
  logic [SW-1:0]  src;
  logic [W-1:0]   mux_word;
  logic           mux_err;

  assign scan_mode  = (bus.mode == MODE_SCAN);
  assign src        = scan_mode ? scan_idx_q : bus.sel;
  assign take       = bus.en & (~vld_q | bus.dout_ready);
  assign dwell_done = (dcnt_q == DCW'(DWELL - 1));

  mux_word_n #(
    .W  (W),
    .N  (N),
    .SW (SW)
  ) u_word (
    .din_i  (bus.din),
    .idx_i  (src),
    .word_o (mux_word),
    .err_o  (mux_err)
  );

  always_comb begin
    dout_d = dout_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    last_d = last_q;
    err_d  = err_q;
    if (take) begin
      dout_d = mux_word;
      ch_d   = src;
      vld_d  = 1'b1;
      last_d = scan_mode & (scan_idx_q == SW'(N - 1)) & dwell_done;
      err_d  = ~scan_mode & mux_err;
    end else if (vld_q & bus.dout_ready) begin
      vld_d = 1'b0;
    end
  end

  // Manual mode pins the scan position to channel 0, dwell 0, so scan always restarts cleanly.
  always_comb begin
    scan_idx_d = scan_idx_q;
    dcnt_d     = dcnt_q;
    if (!scan_mode) begin
      scan_idx_d = '0;
      dcnt_d     = '0;
    end else if (take) begin
      if (!dwell_done) begin
        dcnt_d = dcnt_q + DCW'(1);
      end else begin
        dcnt_d     = '0;
        scan_idx_d = (scan_idx_q == SW'(N - 1)) ? '0 : scan_idx_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q     <= '0;
      ch_q       <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      scan_idx_q <= '0;
      dcnt_q     <= '0;
    end else begin
      dout_q     <= dout_d;
      ch_q       <= ch_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      err_q      <= err_d;
      scan_idx_q <= scan_idx_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_ch    = ch_q;
  assign bus.dout_valid = vld_q;
  assign bus.dout_last  = last_q;
  assign bus.dout_err   = err_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Bench for scan_mux_reg: two configurations (8x4 dwell 2, 4x3 dwell 1) checked against a
// position-counting reference model, with directed scenarios followed by random traffic.
module tb_scan_mux_reg;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  scan_mux_reg_if #(.W(8), .N(4)) a_if ();
  scan_mux_reg_if #(.W(4), .N(3)) b_if ();

  scan_mux_reg #(.W(8), .N(4), .DWELL(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  scan_mux_reg #(.W(4), .N(3), .DWELL(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // Reference model: scan position is a flat count of scan-mode takes modulo N*DWELL.
  int          cfg_n[2] = '{4, 3};
  int          cfg_w[2] = '{8, 4};
  int          cfg_d[2] = '{2, 1};
  int          m_pos[2] = '{0, 0};
  logic [31:0] m_dout[2];
  int          m_ch[2];
  logic        m_vld[2];
  logic        m_last[2];
  logic        m_err[2];

  task automatic step_model(input int id, input logic rst, input logic en, input logic mode,
                            input int sel, input logic [31:0] din, input logic rdy);
    int   n, w, d, ch_scan, dw, src;
    logic take;
    n = cfg_n[id];
    w = cfg_w[id];
    d = cfg_d[id];
    if (rst) begin
      m_pos[id] = 0; m_dout[id] = 0; m_ch[id] = 0;
      m_vld[id] = 0; m_last[id] = 0; m_err[id] = 0;
      return;
    end
    take    = en && (!m_vld[id] || rdy);
    ch_scan = (m_pos[id] / d) % n;
    dw      = m_pos[id] % d;
    if (take) begin
      src        = mode ? ch_scan : sel;
      m_ch[id]   = src;
      m_vld[id]  = 1'b1;
      m_err[id]  = !mode && (sel >= n);
      m_dout[id] = m_err[id] ? 32'd0 : ((din >> (src * w)) & ((32'd1 << w) - 32'd1));
      m_last[id] = mode && (ch_scan == n - 1) && (dw == d - 1);
    end else if (m_vld[id] && rdy) begin
      m_vld[id] = 1'b0;
    end
    if (!mode) m_pos[id] = 0;
    else if (take) m_pos[id] = (m_pos[id] + 1) % (n * d);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("a_dout", 32'(a_if.dout), m_dout[0]);
    chk("a_ch",   32'(a_if.dout_ch), 32'(m_ch[0]));
    chk("a_vld",  32'(a_if.dout_valid), 32'(m_vld[0]));
    chk("a_last", 32'(a_if.dout_last), 32'(m_last[0]));
    chk("a_err",  32'(a_if.dout_err), 32'(m_err[0]));
    chk("b_dout", 32'(b_if.dout), m_dout[1]);
    chk("b_ch",   32'(b_if.dout_ch), 32'(m_ch[1]));
    chk("b_vld",  32'(b_if.dout_valid), 32'(m_vld[1]));
    chk("b_last", 32'(b_if.dout_last), 32'(m_last[1]));
    chk("b_err",  32'(b_if.dout_err), 32'(m_err[1]));
  endtask

  task automatic tick();
    step_model(0, reset, a_if.en, a_if.mode, int'(a_if.sel), 32'(a_if.din), a_if.dout_ready);
    step_model(1, reset, b_if.en, b_if.mode, int'(b_if.sel), 32'(b_if.din), b_if.dout_ready);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int exp_ch[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    reset = 1'b1;
    a_if.en = 0; a_if.mode = 0; a_if.sel = 0; a_if.din = 0; a_if.dout_ready = 0;
    b_if.en = 0; b_if.mode = 0; b_if.sel = 0; b_if.din = 0; b_if.dout_ready = 0;
    tick();
    tick();
    chk("rst_vld", 32'(a_if.dout_valid), 0);
    chk("rst_dout", 32'(a_if.dout), 0);
    reset = 1'b0;

    // Manual select of channel 2
    a_if.din = 32'hD4C3B2A1; a_if.en = 1; a_if.dout_ready = 1; a_if.sel = 2;
    tick();
    chk("man_dout", 32'(a_if.dout), 32'hC3);
    chk("man_ch", 32'(a_if.dout_ch), 2);
    chk("man_vld", 32'(a_if.dout_valid), 1);
    chk("man_err", 32'(a_if.dout_err), 0);
    chk("man_last", 32'(a_if.dout_last), 0);

    // Scan with dwell 2: frame end only on the second channel-3 sample
    a_if.mode = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("scan_ch", 32'(a_if.dout_ch), 32'(exp_ch[i]));
      chk("scan_last", 32'(a_if.dout_last), (i == 7) ? 32'd1 : 32'd0);
    end

    // Backpressure: five stalled cycles while din churns
    a_if.dout_ready = 0;
    for (int i = 0; i < 5; i++) begin
      a_if.din = $urandom;
      tick();
      chk("stall_ch", 32'(a_if.dout_ch), 0);
      chk("stall_vld", 32'(a_if.dout_valid), 1);
    end
    a_if.dout_ready = 1;
    tick();
    chk("resume_ch0", 32'(a_if.dout_ch), 0);
    tick();
    chk("resume_ch1", 32'(a_if.dout_ch), 1);

    // Reset in the middle of channel 1's dwell
    reset = 1'b1;
    tick();
    chk("midrst_vld", 32'(a_if.dout_valid), 0);
    chk("midrst_ch", 32'(a_if.dout_ch), 0);
    reset = 1'b0;
    tick();
    chk("postrst_ch", 32'(a_if.dout_ch), 0);
    chk("postrst_vld", 32'(a_if.dout_valid), 1);

    // Out-of-range manual select on the 3-channel instance
    b_if.din = 12'h5A3; b_if.en = 1; b_if.dout_ready = 1; b_if.mode = 0; b_if.sel = 3;
    tick();
    chk("oor_dout", 32'(b_if.dout), 0);
    chk("oor_ch", 32'(b_if.dout_ch), 3);
    chk("oor_err", 32'(b_if.dout_err), 1);
    b_if.sel = 1;
    tick();
    chk("inr_dout", 32'(b_if.dout), 32'hA);
    chk("inr_err", 32'(b_if.dout_err), 0);

    // Mode switch: scan to channel 1, two manual samples, back to scan from channel 0
    b_if.mode = 1;
    tick();
    chk("ms_ch0", 32'(b_if.dout_ch), 0);
    tick();
    chk("ms_ch1", 32'(b_if.dout_ch), 1);
    b_if.mode = 0; b_if.sel = 2;
    tick();
    chk("ms_man1", 32'(b_if.dout_ch), 2);
    tick();
    chk("ms_man2", 32'(b_if.dout_ch), 2);
    b_if.mode = 1;
    tick();
    chk("ms_rescan", 32'(b_if.dout_ch), 0);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      a_if.en         = ($urandom_range(0, 3) != 0);
      a_if.mode       = ($urandom_range(0, 3) != 0);
      a_if.sel        = 2'($urandom_range(0, 3));
      a_if.din        = $urandom;
      a_if.dout_ready = ($urandom_range(0, 2) != 0);
      b_if.en         = ($urandom_range(0, 3) != 0);
      b_if.mode       = ($urandom_range(0, 2) != 0);
      b_if.sel        = 2'($urandom_range(0, 3));
      b_if.din        = 12'($urandom);
      b_if.dout_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
